// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : Stall/flush sequencing for the 5-stage RV32I pipeline.
// Revision : 1.0
// ============================================================================
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_branch,
  input  logic             id_jumpr,
  input  logic             id_redirect,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_reg_write,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_mem_read,
  input  logic             ex_mem_mem_write,
  input  logic             ex_mem_halt,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [15:0] c_timeout = 16'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_MEM_WAIT   = 2'd1,
    S_HALT_DRAIN = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_inc;
  logic        r_drain_cnt;
  logic        w_waiting;
  logic        w_timeout;
  logic        w_is_br;
  logic        w_load_use;
  logic        w_br_ex;
  logic        w_br_ld;
  logic        w_mem_busy;
  logic        w_data_stall;
  logic        w_eval_run;

  assign w_is_br    = id_branch | id_jumpr;
  assign w_load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (id_ex_rd == id_rs2)));
  // JALR only reads rs1, so rs2 is compared for conditional branches alone
  assign w_br_ex    = w_is_br && id_ex_reg_write && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == id_rs1) || (id_branch && (id_ex_rd == id_rs2)));
  assign w_br_ld    = w_is_br && ex_mem_mem_read && (ex_mem_rd != 5'd0) &&
                      ((ex_mem_rd == id_rs1) || (id_branch && (ex_mem_rd == id_rs2)));
  assign w_mem_busy   = (ex_mem_mem_read | ex_mem_mem_write) & ~dmem_ready;
  assign w_data_stall = w_load_use | w_br_ex | w_br_ld;
  // The cycle DMEM completes is treated exactly like a RUN cycle
  assign w_eval_run   = (r_state == S_RUN) || ((r_state == S_MEM_WAIT) && dmem_ready);
  assign w_wait_inc   = r_wait_cnt + 16'd1;
  assign w_timeout    = w_waiting && (w_wait_inc == c_timeout);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    w_waiting    = 1'b0;
    w_next_state = r_state;
    if (w_eval_run) begin
      w_next_state = S_RUN;
      if (ex_mem_halt) begin
        pc_stall     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        w_next_state = S_HALT_DRAIN;
      end else if (w_mem_busy) begin
        w_waiting = 1'b1;
      end else if (w_data_stall) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (id_redirect) begin
        if_id_flush = 1'b1;
      end
    end else begin
      case (r_state)
        S_MEM_WAIT: w_waiting = 1'b1;
        S_HALT_DRAIN: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (r_drain_cnt) w_next_state = S_HALTED;
        end
        default: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
      endcase
    end
    if (w_waiting) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
      w_next_state = w_timeout ? S_RUN : S_MEM_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_wait_cnt   <= 16'd0;
      r_drain_cnt  <= 1'b0;
      mem_err      <= 1'b0;
      halted       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      r_state     <= w_next_state;
      r_wait_cnt  <= (w_waiting && !w_timeout) ? w_wait_inc : 16'd0;
      r_drain_cnt <= (r_state == S_HALT_DRAIN);
      halted      <= (w_next_state == S_HALTED);
      if (w_timeout) mem_err <= 1'b1;
      if (pc_stall && (stall_cycles != {CNT_W{1'b1}})) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
`default_nettype wire
